alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter: ZERO_REG, 1, when 1 register r0 reads as 0 and ignores writes.
REQ-002 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 instr_valid  in  1  instruction offered; instr_ready  out  1  sequencer can accept.
REQ-005 instr_op  in  3  ALU opcode (000 add .. 111 signed less-than); instr_rd/instr_rs/instr_rt  in  2 each  register indices.
REQ-006 instr_imm  in  8  immediate; instr_use_imm  in  1  select imm instead of rf[rt] for operand b.
REQ-007 alu_a, alu_b  out  8  and alu_op  out  3  drive the downstream 8-bit combinational ALU.
REQ-008 alu_result  in  8, alu_zero  in  1, alu_overflow  in  1  returned by the ALU in the same cycle.
REQ-009 wb_valid  out  1  write-back pulse; wb_rd  out  2; wb_data  out  8.
REQ-010 flag_zero  out  1  last result zero; flag_ovf  out  1  sticky overflow; clr_flags  in  1  clears flag_ovf.
REQ-011 dbg_addr  in  2; dbg_data  out  8  combinational read of the register file (r0 reads 0 when ZERO_REG=1).

Function
REQ-012 SHALL hold a 4 x 8-bit register file r0..r3.
REQ-013 FSM states IDLE and EXEC only; instr_ready = 1 exactly when state is IDLE and rst_n is high.
REQ-014 IDLE: on instr_valid && instr_ready at a rising edge, capture op, rd, a = rf[rs], b = instr_use_imm ? instr_imm : rf[rt]; go EXEC.
REQ-015 EXEC: alu_a/alu_b/alu_op present captured values for the whole cycle; at the ending edge write alu_result to rf[rd], update flags, pulse wb_valid for one cycle, go IDLE.
REQ-016 Latency: accept at edge N; wb_valid, wb_rd, wb_data valid during cycle after edge N+1; instr_ready high again in that same cycle; max throughput one instruction per 2 cycles.
REQ-017 Operands read at acceptance; write-back always completes before the next acceptance, so no forwarding is needed and back-to-back dependent instructions see updated values.
REQ-018 instr_valid high while in EXEC SHALL NOT be accepted; instruction fields may change freely while not accepted.
REQ-019 alu_a/alu_b/alu_op outside EXEC SHALL hold the last captured values (0 after reset).
REQ-020 Write to r0 with ZERO_REG=1 discarded; wb_valid still pulses with wb_data = alu_result.
REQ-021 flag_zero <= alu_zero at each write-back; flag_ovf <= flag_ovf | alu_overflow at each write-back.
REQ-022 clr_flags at an edge clears flag_ovf; if coincident with a write-back carrying alu_overflow=1, flag_ovf SHALL be 1 (set wins).
REQ-023 All arithmetic is the ALU's; the sequencer performs no width extension or truncation; all data paths 8 bits.

Reset
REQ-024 rst_n low SHALL immediately force state IDLE, r0..r3 = 0, alu_a/alu_b/alu_op = 0, wb_valid = 0, wb_rd = 0, wb_data = 0, flag_zero = 0, flag_ovf = 0, instr_ready = 0.
REQ-025 Reset asserted during EXEC SHALL drop the instruction: no register write, no wb_valid.
REQ-026 First acceptance possible at the first rising edge after rst_n deasserts.

Structure
REQ-027 Package alu_seq_pkg SHALL hold opcode constants (OP_ADD..OP_SLT), state encoding, data width 8, register-index width 2.
REQ-028 One sub-module alu_regfile: 4 x 8, two read ports plus debug read port, one write port, honours ZERO_REG.
REQ-029 The ALU is instantiated outside alu_sequencer and connected via the alu_* ports.

Verification (bench attaches a reference ALU)
REQ-030 Reset: after rst_n rises, dbg_data = 0 for all addresses, instr_ready = 1, flags = 0, wb_valid never pulses.
REQ-031 ADD r1=r0+imm 0x7F, then ADD r2=r1+imm 0x01 -> wb_data 0x7F then 0x80; flag_ovf = 1 after second, stays 1 through a following ADD r3=r0+imm 0x05.
REQ-032 SUB r3=r1-r1 (rt=1, use_imm=0) with r1=0x7F -> wb_data 0x00, flag_zero = 1; next ADD r3=r0+imm 0x02 -> flag_zero = 0.
REQ-033 instr_valid held high 6 cycles with one fixed instruction -> exactly 3 acceptances, instr_ready alternates 1/0, wb_valid every second cycle.
REQ-034 ADD r0=r0+imm 0x55 -> wb_valid=1, wb_data=0x55, dbg_data(r0)=0; clr_flags coincident with an overflowing write-back -> flag_ovf stays 1.
REQ-035 rst_n pulsed low during EXEC of ADD r1=r0+imm 0x33 -> no wb_valid, dbg_data(r1)=0 afterwards.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared constants and types for the ALU sequencer: data and register-index
// widths, ALU opcode encodings and the sequencer state encoding.
package alu_seq_pkg;

   localparam int DATA_W   = 8;
   localparam int REG_W    = 2;
   localparam int NUM_REGS = 1 << REG_W;
   localparam int OP_W     = 3;

   typedef logic [DATA_W-1:0] data_t;
   typedef logic [REG_W-1:0]  reg_idx_t;
   typedef logic [OP_W-1:0]   op_t;

   localparam op_t OP_ADD = 3'b000;
   localparam op_t OP_SUB = 3'b001;
   localparam op_t OP_AND = 3'b010;
   localparam op_t OP_OR  = 3'b011;
   localparam op_t OP_XOR = 3'b100;
   localparam op_t OP_SHL = 3'b101;
   localparam op_t OP_SHR = 3'b110;
   localparam op_t OP_SLT = 3'b111;

   typedef enum logic {
      IDLE = 1'b0,
      EXEC = 1'b1
   } state_e;

endpackage

// File: rtl/alu_seq_if.sv
// Instruction-issue and write-back channel of the ALU sequencer. The master
// side offers instructions and observes write-backs; the slave side is the
// sequencer itself.
interface alu_seq_if;
   import alu_seq_pkg::*;

   logic     instr_valid;
   logic     instr_ready;
   op_t      instr_op;
   reg_idx_t instr_rd;
   reg_idx_t instr_rs;
   reg_idx_t instr_rt;
   data_t    instr_imm;
   logic     instr_use_imm;

   logic     wb_valid;
   reg_idx_t wb_rd;
   data_t    wb_data;

   modport master (
      output instr_valid, instr_op, instr_rd, instr_rs, instr_rt,
             instr_imm, instr_use_imm,
      input  instr_ready, wb_valid, wb_rd, wb_data
   );

   modport slave (
      input  instr_valid, instr_op, instr_rd, instr_rs, instr_rt,
             instr_imm, instr_use_imm,
      output instr_ready, wb_valid, wb_rd, wb_data
   );

endinterface

// File: rtl/alu_regfile.sv
// 4 x 8-bit register file with two operand read ports, one debug read port
// and one write port. With ZERO_REG set, r0 is hard-wired to zero.
module alu_regfile
   import alu_seq_pkg::*;
#(
   parameter bit ZERO_REG = 1'b1
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     we,
   input  reg_idx_t waddr,
   input  data_t    wdata,
   input  reg_idx_t raddr_a,
   output data_t    rdata_a,
   input  reg_idx_t raddr_b,
   output data_t    rdata_b,
   input  reg_idx_t dbg_addr,
   output data_t    dbg_data
);

   data_t regs [NUM_REGS];

   function automatic data_t read_reg(input reg_idx_t idx);
      if (ZERO_REG && (idx == '0)) begin
         return '0;
      end
      return regs[idx];
   endfunction

   // Register storage: cleared by reset, writes to r0 dropped when it is the zero register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (we && !(ZERO_REG && (waddr == '0))) begin
         regs[waddr] <= wdata;
      end
   end

   assign rdata_a  = read_reg(raddr_a);
   assign rdata_b  = read_reg(raddr_b);
   assign dbg_data = read_reg(dbg_addr);

endmodule

// File: rtl/alu_sequencer.sv
// Two-state instruction sequencer in front of an external combinational ALU.
// An instruction is accepted in IDLE, its operands are latched onto the ALU
// inputs for one EXEC cycle, and the ALU result is written back at the end of
// that cycle. Write-back always lands before the next acceptance, so
// dependent instructions issued back-to-back need no forwarding.
module alu_sequencer
   import alu_seq_pkg::*;
#(
   parameter bit ZERO_REG = 1'b1
) (
   input  logic     clk,
   input  logic     rst_n,
   alu_seq_if.slave bus,
   output data_t    alu_a,
   output data_t    alu_b,
   output op_t      alu_op,
   input  data_t    alu_result,
   input  logic     alu_zero,
   input  logic     alu_overflow,
   output logic     flag_zero,
   output logic     flag_ovf,
   input  logic     clr_flags,
   input  reg_idx_t dbg_addr,
   output data_t    dbg_data
);

   state_e   state_q;
   state_e   state_d;
   logic     accept;
   logic     writeback;
   logic     ready_c;
   reg_idx_t rd_q;
   data_t    rdata_a;
   data_t    rdata_b;
   logic     wb_valid_q;
   reg_idx_t wb_rd_q;
   data_t    wb_data_q;

   alu_regfile #(
      .ZERO_REG (ZERO_REG)
   ) u_regfile (
      .clk      (clk),
      .rst_n    (rst_n),
      .we       (writeback),
      .waddr    (rd_q),
      .wdata    (alu_result),
      .raddr_a  (bus.instr_rs),
      .rdata_a  (rdata_a),
      .raddr_b  (bus.instr_rt),
      .rdata_b  (rdata_b),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data)
   );

   // State register; reset abandons any instruction in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: accept only in IDLE, write back at the end of every EXEC cycle.
   always_comb begin
      state_d   = state_q;
      accept    = 1'b0;
      writeback = 1'b0;
      ready_c   = 1'b0;
      case (state_q)
         IDLE: begin
            ready_c = rst_n;
            if (bus.instr_valid && rst_n) begin
               accept  = 1'b1;
               state_d = EXEC;
            end
         end
         EXEC: begin
            writeback = 1'b1;
            state_d   = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Operand capture at acceptance; the ALU inputs hold these values until the next acceptance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_a  <= '0;
         alu_b  <= '0;
         alu_op <= '0;
         rd_q   <= '0;
      end else if (accept) begin
         alu_a  <= rdata_a;
         alu_b  <= bus.instr_use_imm ? bus.instr_imm : rdata_b;
         alu_op <= bus.instr_op;
         rd_q   <= bus.instr_rd;
      end
   end

   // Write-back report: one-cycle valid pulse, destination and data held until the next one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_valid_q <= 1'b0;
         wb_rd_q    <= '0;
         wb_data_q  <= '0;
      end else begin
         wb_valid_q <= writeback;
         if (writeback) begin
            wb_rd_q   <= rd_q;
            wb_data_q <= alu_result;
         end
      end
   end

   // Status flags: zero tracks the last result, overflow is sticky and a new overflow beats a clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flag_zero <= 1'b0;
         flag_ovf  <= 1'b0;
      end else begin
         if (writeback) begin
            flag_zero <= alu_zero;
         end
         flag_ovf <= (clr_flags ? 1'b0 : flag_ovf) | (writeback & alu_overflow);
      end
   end

   assign bus.instr_ready = ready_c;
   assign bus.wb_valid    = wb_valid_q;
   assign bus.wb_rd       = wb_rd_q;
   assign bus.wb_data     = wb_data_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed testbench for alu_sequencer with a reference ALU attached to the
// alu_* ports, a register/flag model, and a write-back scoreboard.
module tb_alu_sequencer;
   import alu_seq_pkg::*;

   typedef struct packed {
      logic [1:0] rd;
      logic [7:0] data;
   } wb_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic [2:0] alu_op;
   logic [7:0] alu_result;
   logic       alu_zero;
   logic       alu_overflow;
   logic       flag_zero;
   logic       flag_ovf;
   logic       clr_flags;
   logic [1:0] dbg_addr;
   logic [7:0] dbg_data;

   int checks = 0;
   int failures = 0;
   int accepts;

   logic [7:0] modelRf [4];
   logic       modelFz;
   logic       modelFov;
   wb_t        sb[$];
   logic [7:0] expA;
   logic [7:0] expB;

   alu_seq_if bus();

   alu_sequencer #(
      .ZERO_REG (1'b1)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (bus),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_op       (alu_op),
      .alu_result   (alu_result),
      .alu_zero     (alu_zero),
      .alu_overflow (alu_overflow),
      .flag_zero    (flag_zero),
      .flag_ovf     (flag_ovf),
      .clr_flags    (clr_flags),
      .dbg_addr     (dbg_addr),
      .dbg_data     (dbg_data)
   );

   always #5 clk = ~clk;

   // Reference ALU: returns {overflow, zero, result}.
   function automatic logic [9:0] refAlu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      logic [7:0] r;
      logic       ov;
      r  = 8'h00;
      ov = 1'b0;
      case (op)
         OP_ADD: begin r = a + b; ov = (a[7] == b[7]) && (r[7] != a[7]); end
         OP_SUB: begin r = a - b; ov = (a[7] != b[7]) && (r[7] != a[7]); end
         OP_AND: r = a & b;
         OP_OR:  r = a | b;
         OP_XOR: r = a ^ b;
         OP_SHL: r = a << b[2:0];
         OP_SHR: r = a >> b[2:0];
         default: r = {7'b0000000, ($signed(a) < $signed(b))};
      endcase
      return {ov, (r == 8'h00), r};
   endfunction

   always_comb begin
      {alu_overflow, alu_zero, alu_result} = refAlu(alu_op, alu_a, alu_b);
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic checkReg(input string tag, input logic [1:0] idx);
      dbg_addr = idx;
      #1;
      checkOutput(tag, dbg_data, modelRf[idx]);
   endtask

   // Model of one accepted instruction: operands, result, register and flag update.
   task automatic modelAccept(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs,
                              input logic [1:0] rt, input logic [7:0] imm, input logic useImm,
                              input logic clr, output logic [7:0] a, output logic [7:0] b);
      logic [9:0] res;
      wb_t        item;
      a   = (rs == 2'd0) ? 8'h00 : modelRf[rs];
      b   = useImm ? imm : ((rt == 2'd0) ? 8'h00 : modelRf[rt]);
      res = refAlu(op, a, b);
      item.rd   = rd;
      item.data = res[7:0];
      sb.push_back(item);
      if (rd != 2'd0) modelRf[rd] = res[7:0];
      modelFz  = res[8];
      modelFov = (clr ? 1'b0 : modelFov) | res[9];
   endtask

   // Issue one instruction and follow it through EXEC to its write-back cycle.
   task automatic applyStimulus(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs,
                                input logic [1:0] rt, input logic [7:0] imm, input logic useImm,
                                input logic clrAtWb);
      logic [7:0] a;
      logic [7:0] b;
      @(negedge clk);
      bus.instr_op      = op;
      bus.instr_rd      = rd;
      bus.instr_rs      = rs;
      bus.instr_rt      = rt;
      bus.instr_imm     = imm;
      bus.instr_use_imm = useImm;
      bus.instr_valid   = 1'b1;
      checkOutput("ready_idle", bus.instr_ready, 1);
      modelAccept(op, rd, rs, rt, imm, useImm, clrAtWb, a, b);
      @(negedge clk);
      bus.instr_valid   = 1'b0;
      bus.instr_op      = 3'($urandom);
      bus.instr_rd      = 2'($urandom);
      bus.instr_rs      = 2'($urandom);
      bus.instr_rt      = 2'($urandom);
      bus.instr_imm     = 8'($urandom);
      bus.instr_use_imm = 1'($urandom);
      clr_flags         = clrAtWb;
      checkOutput("ready_exec", bus.instr_ready, 0);
      checkOutput("alu_op_exec", alu_op, op);
      checkOutput("alu_a_exec", alu_a, a);
      checkOutput("alu_b_exec", alu_b, b);
      @(negedge clk);
      clr_flags = 1'b0;
      checkOutput("ready_after_wb", bus.instr_ready, 1);
      checkOutput("alu_b_hold", alu_b, b);
      checkOutput("flag_zero", flag_zero, modelFz);
      checkOutput("flag_ovf", flag_ovf, modelFov);
   endtask

   // Write-back monitor: every wb_valid pulse must match the oldest expected result.
   always @(negedge clk) begin
      wb_t item;
      if (bus.wb_valid === 1'b1) begin
         checks++;
         assert (sb.size() > 0) else begin
            failures++;
            $error("[TB] FAIL wb_unexpected observed=wb_valid=1 expected=no write-back pending");
         end
         if (sb.size() > 0) begin
            item = sb.pop_front();
            checkOutput("wb_rd", bus.wb_rd, item.rd);
            checkOutput("wb_data", bus.wb_data, item.data);
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=completion");
      $fatal(1, "[TB] simulation did not finish");
   end

   initial begin
      bus.instr_valid   = 1'b0;
      bus.instr_op      = 3'd0;
      bus.instr_rd      = 2'd0;
      bus.instr_rs      = 2'd0;
      bus.instr_rt      = 2'd0;
      bus.instr_imm     = 8'd0;
      bus.instr_use_imm = 1'b0;
      clr_flags         = 1'b0;
      dbg_addr          = 2'd0;
      for (int i = 0; i < 4; i++) modelRf[i] = 8'h00;
      modelFz  = 1'b0;
      modelFov = 1'b0;

      // Reset values while rst_n is low and after release.
      #12;
      checkOutput("rst_ready_low", bus.instr_ready, 0);
      checkOutput("rst_wb_valid", bus.wb_valid, 0);
      checkOutput("rst_alu_op", alu_op, 0);
      checkOutput("rst_alu_a", alu_a, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("rst_ready_high", bus.instr_ready, 1);
      checkOutput("rst_flag_zero", flag_zero, 0);
      checkOutput("rst_flag_ovf", flag_ovf, 0);
      for (int i = 0; i < 4; i++) checkReg("rst_reg", 2'(i));

      // Signed overflow into r2, sticky through a clean add.
      applyStimulus(OP_ADD, 2'd1, 2'd0, 2'd0, 8'h7F, 1'b1, 1'b0);
      checkOutput("add1_data", bus.wb_data, 8'h7F);
      checkOutput("add1_ovf", flag_ovf, 0);
      applyStimulus(OP_ADD, 2'd2, 2'd1, 2'd0, 8'h01, 1'b1, 1'b0);
      checkOutput("add2_data", bus.wb_data, 8'h80);
      checkOutput("add2_ovf", flag_ovf, 1);
      applyStimulus(OP_ADD, 2'd3, 2'd0, 2'd0, 8'h05, 1'b1, 1'b0);
      checkOutput("add3_ovf_sticky", flag_ovf, 1);

      // Register-register subtract giving zero, then a non-zero result.
      applyStimulus(OP_SUB, 2'd3, 2'd1, 2'd1, 8'hAA, 1'b0, 1'b0);
      checkOutput("sub_data", bus.wb_data, 8'h00);
      checkOutput("sub_zero", flag_zero, 1);
      applyStimulus(OP_ADD, 2'd3, 2'd0, 2'd0, 8'h02, 1'b1, 1'b0);
      checkOutput("add_nonzero", flag_zero, 0);

      // A few other opcodes through register operands.
      applyStimulus(OP_XOR, 2'd3, 2'd2, 2'd1, 8'h00, 1'b0, 1'b0);
      applyStimulus(OP_SLT, 2'd3, 2'd2, 2'd1, 8'h00, 1'b0, 1'b0);
      checkOutput("slt_data", bus.wb_data, 8'h01);
      applyStimulus(OP_SHR, 2'd3, 2'd2, 2'd0, 8'h03, 1'b1, 1'b0);

      // Valid held high for six cycles: three dependent acceptances.
      accepts = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i == 0) begin
            bus.instr_op      = OP_ADD;
            bus.instr_rd      = 2'd2;
            bus.instr_rs      = 2'd2;
            bus.instr_rt      = 2'd0;
            bus.instr_imm     = 8'h10;
            bus.instr_use_imm = 1'b1;
            bus.instr_valid   = 1'b1;
         end
         checkOutput("tp_ready", bus.instr_ready, (i % 2 == 0) ? 1 : 0);
         checkOutput("tp_wb_valid", bus.wb_valid, (i >= 2 && i % 2 == 0) ? 1 : 0);
         if (bus.instr_ready === 1'b1) begin
            accepts++;
            modelAccept(OP_ADD, 2'd2, 2'd2, 2'd0, 8'h10, 1'b1, 1'b0, expA, expB);
         end
      end
      @(negedge clk);
      bus.instr_valid = 1'b0;
      checkOutput("tp_accepts", accepts, 3);
      checkReg("tp_r2", 2'd2);

      // Write to the zero register.
      applyStimulus(OP_ADD, 2'd0, 2'd0, 2'd0, 8'h55, 1'b1, 1'b0);
      checkOutput("r0_wb_data", bus.wb_data, 8'h55);
      checkOutput("r0_wb_rd", bus.wb_rd, 0);
      dbg_addr = 2'd0;
      #1;
      checkOutput("r0_dbg", dbg_data, 8'h00);

      // Clear on its own, then clear coincident with an overflowing write-back.
      @(negedge clk);
      clr_flags = 1'b1;
      @(negedge clk);
      clr_flags = 1'b0;
      modelFov  = 1'b0;
      checkOutput("clr_ovf", flag_ovf, 0);
      applyStimulus(OP_ADD, 2'd2, 2'd1, 2'd0, 8'h01, 1'b1, 1'b1);
      checkOutput("clr_set_wins", flag_ovf, 1);

      // Reset during EXEC drops the instruction.
      @(negedge clk);
      bus.instr_op      = OP_ADD;
      bus.instr_rd      = 2'd1;
      bus.instr_rs      = 2'd0;
      bus.instr_imm     = 8'h33;
      bus.instr_use_imm = 1'b1;
      bus.instr_valid   = 1'b1;
      @(posedge clk);
      #2;
      rst_n           = 1'b0;
      bus.instr_valid = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) modelRf[i] = 8'h00;
      modelFz  = 1'b0;
      modelFov = 1'b0;
      checkOutput("mid_rst_ready", bus.instr_ready, 0);
      checkOutput("mid_rst_alu_a", alu_a, 0);
      checkOutput("mid_rst_ovf", flag_ovf, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checkOutput("post_rst_wb_valid", bus.wb_valid, 0);
      checkReg("post_rst_r1", 2'd1);

      // First instruction after reset.
      applyStimulus(OP_ADD, 2'd1, 2'd0, 2'd0, 8'h33, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) checkReg("final_reg", 2'(i));
      checks++;
      assert (sb.size() == 0) else begin
         failures++;
         $error("[TB] FAIL sb_empty observed=%0d expected=0", sb.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
